wb_ext_arbiter: RTL and testbench
=================================

Name: wb_ext_arbiter

Overview:
- Two-master to one-slave pipelined Wishbone arbiter for the SoC external-IO bus (30-bit word address, 32-bit data, 4-bit select).
- Shares the external-IO slave between the CPU master (m0) and the hardware-debugger master (m1).
- Round-robin grant, held for the owner's whole cyc.
- Tracks outstanding transfers and completes hung ones with a watchdog timeout so neither master deadlocks.

Parameters:
- ADR_W, 30, address width (word address).
- DAT_W, 32, data width.
- SEL_W, 4, byte-select width.
- MAX_OUT, 15, max outstanding accepted-but-unacked transfers; counter width is clog2(MAX_OUT+1).
- TIMEOUT, 255, cycles without slave ack, while outstanding>0, before a synthetic ack is issued.

Ports:
- system_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- m0_adr / m1_adr  in  ADR_W  master address.
- m0_dat_w / m1_dat_w  in  DAT_W  master write data.
- m0_sel / m1_sel  in  SEL_W  master byte selects.
- m0_cyc, m0_stb, m0_we / m1_cyc, m1_stb, m1_we  in  1 each  master cycle, strobe and write enable.
- m0_dat_r / m1_dat_r  out  DAT_W  master read data.
- m0_ack, m0_stall / m1_ack, m1_stall  out  1 each  master acknowledge and stall.
- s_adr  out  ADR_W; s_dat_w  out  DAT_W; s_sel  out  SEL_W.
- s_cyc, s_stb, s_we  out  1 each  slave-side request.
- s_dat_r  in  DAT_W; s_ack, s_stall  in  1 each  slave response.
- grant  out  2  one-hot owner; 00 when idle.
- timeout_flag  out  1  sticky; set on any watchdog completion.
- timeout_clr  in  1  clears timeout_flag.

Behaviour:
- Reset (sync, rst=1 at clock edge):
  - state=IDLE, grant=00, outstanding=0, wd_cnt=0, timeout_flag=0, last=m1, so m0 wins the first contention.
  - Combinational outputs while idle: s_cyc=s_stb=0, m*_ack=0, m*_stall=1, m*_dat_r=0.
- IDLE:
  - A master requests when its cyc=1.
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last.
  - Grant registers, so the owner's first stb can be accepted in the cycle after cyc rises (1-cycle arbitration latency).
  - All stalls stay 1 in IDLE; no transfer is accepted.
- BUSY(owner):
  - s_adr/dat_w/sel/we come combinationally from the owner.
  - s_cyc = owner cyc; s_stb = owner stb & (outstanding<MAX_OUT).
  - Owner stall = s_stall | (outstanding==MAX_OUT).
  - Owner ack = s_ack | wd_fire; owner dat_r = s_dat_r, or all-ones on wd_fire.
  - Non-owner: stall=1, ack=0, dat_r=0.
- Outstanding counter:
  - +1 when s_stb & ~s_stall.
  - −1 on s_ack or wd_fire.
  - Both in the same cycle: net 0.
  - Never underflows; s_ack seen with outstanding=0 is ignored and not forwarded.
- Watchdog:
  - wd_cnt clears on any s_ack or when outstanding==0; otherwise increments.
  - wd_fire = (wd_cnt==TIMEOUT-1) & ~s_ack. It completes exactly one transfer, sets timeout_flag and clears wd_cnt.
  - Further hung transfers each take another TIMEOUT cycles.
- Release:
  - Owner cyc=0 → next state IDLE, last=owner, grant=00, outstanding=0, wd_cnt=0.
  - This covers abort with outstanding>0: late slave acks are dropped because s_cyc is low.
  - Re-grant occurs no earlier than the next cycle, so back-to-back ownership changes have at least one idle cycle.
- Non-owner cyc rising mid-BUSY waits; it is granted after release if it is still requesting.
- timeout_flag: set wins over timeout_clr when both occur in the same cycle.
- rst mid-transfer: immediate return to reset state; slave sees s_cyc=0 in the following cycle.

Decomposition:
- Package wb_ext_pkg:
  - Address/data/select widths.
  - Master and slave request/response struct typedefs matching the SoC ext-IO bus.
  - State enum {IDLE, BUSY}.
  - Watchdog read-data constant (all-ones).
- One natural sub-module: wb_ext_watchdog (outstanding counter + wd_cnt + wd_fire + timeout_flag).
- Grant FSM and muxing stay in the top.

Test Plan:
- Single master:
  - m0 holds cyc, issues 3 pipelined reads to addrs 0x10, 0x11, 0x12.
  - Slave acks with data 0xA0, 0xA1, 0xA2 at latency 2.
  - Required: grant=01 one cycle after cyc; m0 sees three acks in order with that data; m1_stall=1 throughout.
- Contention after reset:
  - m0 and m1 raise cyc in the same cycle.
  - Required: grant=01 first; after m0 drops cyc, one idle cycle, then grant=10.
  - Repeat the simultaneous request: m0 wins again because last=m1.
- Backpressure:
  - Slave holds s_stall=1 for 4 cycles, then accepts.
  - Required: owner stall mirrors it; exactly one transfer counted per accepted stb.
  - With MAX_OUT=2 and no acks: the third stb is stalled.
- Timeout:
  - m1 issues one read; slave never acks.
  - Required: at cycle TIMEOUT after acceptance, m1_ack=1 with dat_r=0xFFFFFFFF and timeout_flag=1.
  - timeout_clr then clears the flag.
- Abort:
  - m0 has 2 outstanding, then drops cyc.
  - Required: s_cyc=0 next cycle; grant=00; outstanding=0; a late s_ack is not forwarded to either master.
- Reset mid-operation:
  - Assert rst during BUSY with 3 outstanding.
  - Required: next cycle grant=00, stalls=1, timeout_flag=0; a subsequent m1 request is granted normally.

Source files
------------

// File: rtl/wb_ext_pkg.sv
// Shared types and constants for the SoC external-IO Wishbone bus.
package wb_ext_pkg;

  localparam int unsigned ADR_W = 30;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [SEL_W-1:0] sel;
    logic             cyc;
    logic             stb;
    logic             we;
  } wb_req_t;

  typedef struct packed {
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             stall;
  } wb_rsp_t;

  typedef enum logic {IDLE, BUSY} state_t;

  // Read data returned when the watchdog completes a hung transfer.
  localparam logic [DAT_W-1:0] WD_DAT = '1;

  // Response seen by any master that does not own the bus.
  localparam wb_rsp_t IDLE_RSP = '{dat_r: '0, ack: 1'b0, stall: 1'b1};

endpackage

// File: rtl/wb_ext_if.sv
// One pipelined Wishbone link: request from master, response from slave.
interface wb_ext_if;
  import wb_ext_pkg::*;

  wb_req_t req;
  wb_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/wb_ext_watchdog.sv
// Outstanding-transfer counter with hung-transfer watchdog and sticky timeout flag.
module wb_ext_watchdog #(
  parameter int unsigned MAX_OUT = 15,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic accept,
  input  logic ack,
  input  logic timeout_clr,
  output logic full_c,
  output logic nonzero_c,
  output logic wd_fire_c,
  output logic timeout_flag
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] outstanding;
  logic [WD_W-1:0]  wd_cnt;
  logic             ack_v_c;

  assign nonzero_c = (outstanding != '0);
  assign full_c    = (outstanding == CNT_W'(MAX_OUT));
  // Acks with nothing outstanding are stray and must not decrement.
  assign ack_v_c   = ack & nonzero_c;
  assign wd_fire_c = ~clear & nonzero_c & ~ack_v_c & (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding  <= '0;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (clear) begin
        outstanding <= '0;
        wd_cnt      <= '0;
      end else begin
        outstanding <= outstanding + CNT_W'(accept) - CNT_W'(ack_v_c | wd_fire_c);
        if (ack || !nonzero_c || wd_fire_c) wd_cnt <= '0;
        else                                wd_cnt <= wd_cnt + WD_W'(1);
      end
      // Set takes priority over clear.
      if (wd_fire_c)        timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Two-master round-robin Wishbone arbiter for the external-IO slave, grant held per cyc.
module wb_ext_arbiter
  import wb_ext_pkg::*;
#(
  parameter int unsigned MAX_OUT = 15,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        system_clk,
  input  logic        rst,
  wb_ext_if.slave     m0,
  wb_ext_if.slave     m1,
  wb_ext_if.master    s,
  output logic [1:0]  grant,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  state_t  state;
  logic    owner;
  logic    last;
  logic    pick_c;
  wb_req_t own_req_c;
  wb_rsp_t own_rsp_c;
  logic    own_active_c;
  logic    accept_c;
  logic    ack_in_c;
  logic    full_c;
  logic    nonzero_c;
  logic    wd_fire_c;

  // On contention, the master that did not own the bus last wins.
  assign pick_c = (m0.req.cyc && m1.req.cyc) ? ~last : m1.req.cyc;

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: if (m0.req.cyc || m1.req.cyc) begin
          state <= BUSY;
          owner <= pick_c;
          grant <= pick_c ? 2'b10 : 2'b01;
        end
        BUSY: if (!own_req_c.cyc) begin
          state <= IDLE;
          last  <= owner;
          grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side request path from the owner.
  always_comb begin
    own_req_c    = owner ? m1.req : m0.req;
    own_active_c = (state == BUSY) && own_req_c.cyc;
    s.req        = '0;
    if (state == BUSY) begin
      s.req     = own_req_c;
      s.req.stb = own_active_c && own_req_c.stb && !full_c;
    end
  end

  assign accept_c = s.req.stb & ~s.rsp.stall;
  // Acks arriving after the owner dropped cyc are discarded.
  assign ack_in_c = own_active_c & s.rsp.ack;

  wb_ext_watchdog #(
    .MAX_OUT (MAX_OUT),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk          (system_clk),
    .rst          (rst),
    .clear        (~own_active_c),
    .accept       (accept_c),
    .ack          (ack_in_c),
    .timeout_clr  (timeout_clr),
    .full_c       (full_c),
    .nonzero_c    (nonzero_c),
    .wd_fire_c    (wd_fire_c),
    .timeout_flag (timeout_flag)
  );

  // Master-side response path; only the owner sees slave activity.
  always_comb begin
    own_rsp_c.stall = s.rsp.stall | full_c;
    own_rsp_c.ack   = (ack_in_c & nonzero_c) | wd_fire_c;
    own_rsp_c.dat_r = wd_fire_c ? WD_DAT : s.rsp.dat_r;
    m0.rsp = IDLE_RSP;
    m1.rsp = IDLE_RSP;
    if (state == BUSY) begin
      if (owner) m1.rsp = own_rsp_c;
      else       m0.rsp = own_rsp_c;
    end
  end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed scoreboard bench for wb_ext_arbiter with a latency-2 slave model.
module tb_wb_ext_arbiter;
  import wb_ext_pkg::*;

  localparam int TO = 255;

  logic       system_clk = 1'b0;
  logic       rst = 1'b1;
  logic       timeout_clr = 1'b0;
  logic [1:0] grant, grant2;
  logic       timeout_flag, flag2;

  wb_req_t r0 = '0, r1 = '0, q0 = '0;
  logic [31:0] sl_dat = '0;
  logic sl_ack = 1'b0, sl_stall = 1'b0, mute = 1'b0;
  int flush_gen = 0, flush_seen = 0, cyc_no = 0, n_acc = 0;
  int n_vec = 0, n_bad = 0;
  logic [31:0] exp0[$], exp1[$];

  typedef struct {logic [31:0] dat; int due;} pend_t;
  pend_t pend[$];

  wb_ext_if m0_bus(); wb_ext_if m1_bus(); wb_ext_if s_bus();
  wb_ext_if b0(); wb_ext_if b1(); wb_ext_if bs();

  assign m0_bus.req = r0;
  assign m1_bus.req = r1;
  assign s_bus.rsp  = '{dat_r: sl_dat, ack: sl_ack, stall: sl_stall};
  assign b0.req     = q0;
  assign b1.req     = '0;
  assign bs.rsp     = '{dat_r: '0, ack: 1'b0, stall: 1'b0};

  wb_ext_arbiter dut (
    .system_clk (system_clk), .rst (rst), .m0 (m0_bus), .m1 (m1_bus), .s (s_bus),
    .grant (grant), .timeout_flag (timeout_flag), .timeout_clr (timeout_clr)
  );

  wb_ext_arbiter #(.MAX_OUT(2), .TIMEOUT(255)) dut2 (
    .system_clk (system_clk), .rst (rst), .m0 (b0), .m1 (b1), .s (bs),
    .grant (grant2), .timeout_flag (flag2), .timeout_clr (1'b0)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge system_clk); #1;
  endtask

  // Slave: acks each accepted request two cycles later, data = 0xA0 + adr[3:0].
  always begin
    logic acc;
    logic [31:0] acc_dat;
    @(negedge system_clk);
    acc     = s_bus.req.cyc && s_bus.req.stb && !s_bus.rsp.stall;
    acc_dat = 32'hA0 + 32'(s_bus.req.adr[3:0]);
    @(posedge system_clk); #2;
    cyc_no++;
    if (flush_seen != flush_gen) begin pend.delete(); flush_seen = flush_gen; end
    if (acc) begin pend.push_back('{dat: acc_dat, due: cyc_no + 1}); n_acc++; end
    if (!mute && pend.size() > 0 && pend[0].due <= cyc_no) begin
      sl_ack = 1'b1; sl_dat = pend[0].dat; void'(pend.pop_front());
    end else begin
      sl_ack = 1'b0; sl_dat = '0;
    end
  end

  // Scoreboard monitor: every master ack must match the oldest expected entry.
  always @(negedge system_clk) begin
    if (m0_bus.rsp.ack) begin
      if (exp0.size() == 0) check("m0 unexpected ack", 32'd1, 32'd0);
      else check("m0 ack data", m0_bus.rsp.dat_r, exp0.pop_front());
    end
    if (m1_bus.rsp.ack) begin
      if (exp1.size() == 0) check("m1 unexpected ack", 32'd1, 32'd0);
      else check("m1 ack data", m1_bus.rsp.dat_r, exp1.pop_front());
    end
  end

  task automatic raise(input logic c0, input logic c1, input logic [1:0] g);
    r0.cyc = c0; r1.cyc = c1;
    @(negedge system_clk); check("grant before arbitration", 32'(grant), 32'd0);
    step();
    @(negedge system_clk); check("grant after arbitration", 32'(grant), 32'(g));
    step();
  endtask

  task automatic master_req(input int m, input logic [29:0] adr, input logic [31:0] exp_dat);
    logic accepted = 1'b0;
    if (m == 0) begin r0.stb = 1'b1; r0.adr = adr; r0.we = 1'b0; end
    else        begin r1.stb = 1'b1; r1.adr = adr; r1.we = 1'b0; end
    for (int i = 0; i < 20; i++) begin
      @(negedge system_clk);
      if (m == 0 && !m0_bus.rsp.stall) begin
        accepted = 1'b1; exp0.push_back(exp_dat);
        check("non-owner m1 stall", 32'(m1_bus.rsp.stall), 32'd1);
      end else if (m == 1 && !m1_bus.rsp.stall) begin
        accepted = 1'b1; exp1.push_back(exp_dat);
        check("non-owner m0 stall", 32'(m0_bus.rsp.stall), 32'd1);
      end
      step();
      if (accepted) break;
    end
    if (!accepted) check("request accepted", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp0.size() + exp1.size()) > 0; i++) step();
    check("scoreboard drained", 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  task automatic wait_ack(input int m, input string name);
    int k = 0;
    for (int i = 0; i < TO + 40; i++) begin
      @(negedge system_clk); k++;
      if ((m == 0 && m0_bus.rsp.ack) || (m == 1 && m1_bus.rsp.ack)) break;
    end
    check(name, 32'(k), 32'(TO));
  endtask

  initial begin
    int n0, n_late;
    repeat (2) step();
    rst = 1'b0;
    @(negedge system_clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset m0 stall", 32'(m0_bus.rsp.stall), 32'd1);
    check("reset m1 stall", 32'(m1_bus.rsp.stall), 32'd1);
    check("reset m0 ack", 32'(m0_bus.rsp.ack), 32'd0);
    check("reset m0 dat_r", m0_bus.rsp.dat_r, 32'd0);
    check("reset s_cyc", 32'(s_bus.req.cyc), 32'd0);
    check("reset flag", 32'(timeout_flag), 32'd0);
    step();

    // MAX_OUT=2 instance, slave never acks: third stb stalls.
    q0.cyc = 1'b1; q0.stb = 1'b1; q0.adr = 30'h7;
    step(); @(negedge system_clk);
    check("d2 grant", 32'(grant2), 32'd1);
    check("d2 stall out=0", 32'(b0.rsp.stall), 32'd0);
    step(); @(negedge system_clk); check("d2 stall out=1", 32'(b0.rsp.stall), 32'd0);
    step(); @(negedge system_clk);
    check("d2 stall out=2", 32'(b0.rsp.stall), 32'd1);
    check("d2 s_stb at max", 32'(bs.req.stb), 32'd0);
    step(); q0 = '0; step();

    // Single master, three pipelined reads.
    raise(1'b1, 1'b0, 2'b01);
    master_req(0, 30'h10, 32'hA0);
    master_req(0, 30'h11, 32'hA1);
    master_req(0, 30'h12, 32'hA2);
    r0.stb = 1'b0; drain();
    r0.cyc = 1'b0; step(); step();

    // Contention after reset.
    rst = 1'b1; step(); rst = 1'b0;
    raise(1'b1, 1'b1, 2'b01);
    master_req(0, 30'h20, 32'hA0);
    r0.stb = 1'b0; drain();
    r0.cyc = 1'b0; step();
    @(negedge system_clk); check("idle gap grant", 32'(grant), 32'd0);
    step();
    @(negedge system_clk); check("handover grant", 32'(grant), 32'd2);
    step();
    master_req(1, 30'h31, 32'hA1);
    r1.stb = 1'b0; drain();
    r1.cyc = 1'b0; step(); step();
    raise(1'b1, 1'b1, 2'b01);
    r0 = '0; r1 = '0; step(); step();

    // Backpressure.
    raise(1'b1, 1'b0, 2'b01);
    n0 = n_acc;
    sl_stall = 1'b1; r0.stb = 1'b1; r0.adr = 30'h13;
    for (int i = 0; i < 4; i++) begin
      @(negedge system_clk); check("stall mirrors slave", 32'(m0_bus.rsp.stall), 32'd1);
      step();
    end
    sl_stall = 1'b0;
    @(negedge system_clk); check("stall released", 32'(m0_bus.rsp.stall), 32'd0);
    exp0.push_back(32'hA3);
    step(); r0.stb = 1'b0;
    @(negedge system_clk); check("outstanding after accept", 32'(dut.u_wd.outstanding), 32'd1);
    drain();
    check("slave accepts", 32'(n_acc - n0), 32'd1);
    r0.cyc = 1'b0; step(); step();

    // Timeout on m1.
    mute = 1'b1;
    raise(1'b0, 1'b1, 2'b10);
    master_req(1, 30'h40, 32'hFFFF_FFFF);
    r1.stb = 1'b0;
    wait_ack(1, "m1 timeout latency");
    step(); r1.cyc = 1'b0;
    @(negedge system_clk); check("flag set", 32'(timeout_flag), 32'd1);
    step(); timeout_clr = 1'b1;
    step(); timeout_clr = 1'b0;
    @(negedge system_clk); check("flag cleared", 32'(timeout_flag), 32'd0);
    step(); flush_gen++; mute = 1'b0; step();

    // Abort with two outstanding; late acks must be dropped.
    mute = 1'b1;
    raise(1'b1, 1'b0, 2'b01);
    master_req(0, 30'h50, 32'h0);
    master_req(0, 30'h51, 32'h0);
    r0.stb = 1'b0;
    @(negedge system_clk); check("abort outstanding before", 32'(dut.u_wd.outstanding), 32'd2);
    step(); r0.cyc = 1'b0;
    @(negedge system_clk); check("abort s_cyc", 32'(s_bus.req.cyc), 32'd0);
    step();
    @(negedge system_clk);
    check("abort grant", 32'(grant), 32'd0);
    check("abort outstanding", 32'(dut.u_wd.outstanding), 32'd0);
    step(); exp0.delete(); mute = 1'b0;
    n_late = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge system_clk);
      if (s_bus.rsp.ack) begin
        n_late++;
        check("late ack m0", 32'(m0_bus.rsp.ack), 32'd0);
        check("late ack m1", 32'(m1_bus.rsp.ack), 32'd0);
      end
      step();
    end
    check("late acks presented", 32'(n_late), 32'd2);
    flush_gen++; step();

    // Timeout with clear held (set wins), then reset mid-transfer.
    raise(1'b1, 1'b0, 2'b01);
    timeout_clr = 1'b1; mute = 1'b1;
    master_req(0, 30'h60, 32'hFFFF_FFFF);
    r0.stb = 1'b0;
    wait_ack(0, "m0 timeout latency");
    step();
    @(negedge system_clk); check("set beats clear", 32'(timeout_flag), 32'd1);
    step(); timeout_clr = 1'b0;
    master_req(0, 30'h61, 32'h0);
    master_req(0, 30'h62, 32'h0);
    master_req(0, 30'h63, 32'h0);
    r0.stb = 1'b0;
    @(negedge system_clk); check("outstanding before rst", 32'(dut.u_wd.outstanding), 32'd3);
    step(); rst = 1'b1;
    step(); rst = 1'b0; r0.cyc = 1'b0; exp0.delete(); flush_gen++; mute = 1'b0;
    @(negedge system_clk);
    check("rst grant", 32'(grant), 32'd0);
    check("rst m0 stall", 32'(m0_bus.rsp.stall), 32'd1);
    check("rst m1 stall", 32'(m1_bus.rsp.stall), 32'd1);
    check("rst flag", 32'(timeout_flag), 32'd0);
    check("rst s_cyc", 32'(s_bus.req.cyc), 32'd0);
    check("rst outstanding", 32'(dut.u_wd.outstanding), 32'd0);
    step();
    raise(1'b0, 1'b1, 2'b10);
    master_req(1, 30'h62, 32'hA2);
    r1.stb = 1'b0; drain();
    r1.cyc = 1'b0; step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
